// File: rtl/serial_comp_pkg.sv
// ============================================================================
// Module      : serial_comp_pkg
// Description : Shared types and helpers for the digit-serial comparator:
//               FSM state encoding, result encoding, counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_comp_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Result vector encoding, ordered {eq, gt, lt}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

  // Digit counter width: clog2(N/D), never narrower than one bit
  function automatic int cnt_width(input int n, input int d);
    int w;
    w = $clog2(n / d);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_cmp.sv
// ============================================================================
// Module      : digit_cmp
// Description : Combinational unsigned compare of one D-bit digit pair.
//               diff_o = digits differ, a_gt_o = digit A greater than B.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_cmp #(
  parameter int D = 4
) (
  input  logic [D-1:0] a_i,
  input  logic [D-1:0] b_i,
  output logic         diff_o,
  output logic         a_gt_o
);

  assign diff_o = (a_i != b_i);
  assign a_gt_o = (a_i > b_i);

endmodule

`default_nettype wire

// File: rtl/serial_comp.sv
// ============================================================================
// Module      : serial_comp
// Description : Digit-serial MSB-first magnitude comparator with start/done
//               handshake and signed/unsigned mode. Signed operands are
//               mapped to offset binary (MSB inverted) so a single unsigned
//               digit compare serves both modes.
//               Optional macro SERIAL_COMP_EARLY_EXIT_EN: finish on the first
//               differing digit instead of always scanning all N/D digits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_comp
  import serial_comp_pkg::*;
#(
  parameter int N = 16,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  localparam int             DIGITS   = N / D;
  localparam int             CW       = cnt_width(N, D);
  localparam logic [CW-1:0]  LAST_CNT = CW'(DIGITS - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   a_sh_q, a_sh_d;
  logic [N-1:0]   b_sh_q, b_sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           decided_q, decided_d;
  logic           gt_lat_q, gt_lat_d;
  logic [2:0]     res_q, res_d;

  logic           w_diff;
  logic           w_a_gt;
  logic           w_accept;
  logic           w_last;
  logic           w_first_hit;
  logic           w_finish;
  logic [N-1:0]   w_sign_flip;

  digit_cmp #(
    .D (D)
  ) u_digit_cmp (
    .a_i    (a_sh_q[N-1 -: D]),
    .b_i    (b_sh_q[N-1 -: D]),
    .diff_o (w_diff),
    .a_gt_o (w_a_gt)
  );

  // Requests are honoured whenever no scan is in progress
  assign w_accept    = start & (state_q != ST_RUN);
  assign w_last      = (cnt_q == LAST_CNT);
  assign w_first_hit = ~decided_q & w_diff;
  assign w_sign_flip = {signed_mode, {(N-1){1'b0}}};

`ifdef SERIAL_COMP_EARLY_EXIT_EN
  // The first differing digit settles the answer, so stop there
  assign w_finish = w_last | w_first_hit;
`else
  assign w_finish = w_last;
`endif

  // Next-state logic for the IDLE/RUN/DONE controller
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)    state_d = ST_RUN;
      ST_RUN:  if (w_finish) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: load on accept, scan one digit per RUN cycle
  always_comb begin
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    gt_lat_d  = gt_lat_q;
    res_d     = res_q;
    if (w_accept) begin
      a_sh_d    = a ^ w_sign_flip;
      b_sh_d    = b ^ w_sign_flip;
      cnt_d     = '0;
      decided_d = 1'b0;
      gt_lat_d  = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (w_first_hit) begin
        decided_d = 1'b1;
        gt_lat_d  = w_a_gt;
      end
      a_sh_d = a_sh_q << D;
      b_sh_d = b_sh_q << D;
      cnt_d  = cnt_q + CW'(1);
      // The final digit's own compare must be folded into the result
      if (w_finish) begin
        if (decided_q)   res_d = gt_lat_q ? RES_GT : RES_LT;
        else if (w_diff) res_d = w_a_gt   ? RES_GT : RES_LT;
        else             res_d = RES_EQ;
      end
    end
  end

  // State and datapath registers with asynchronous abort to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      gt_lat_q  <= 1'b0;
      res_q     <= RES_NONE;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      gt_lat_q  <= gt_lat_d;
      res_q     <= res_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign eq   = res_q[2];
  assign gt   = res_q[1];
  assign lt   = res_q[0];

endmodule

`default_nettype wire

// File: tb/tb_serial_comp.sv
// ============================================================================
// Module      : tb_serial_comp
// Description : Self-checking bench for serial_comp. Three instances:
//               N=16/D=4, N=8/D=8, N=8/D=1. Expected results and latencies
//               are queued when a request is driven and checked at done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_comp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        st   [3];
  logic        sm   [3];
  logic [15:0] a0, b0;
  logic [7:0]  a8   [2];
  logic [7:0]  b8   [2];
  logic        busy [3];
  logic        done [3];
  logic        eq   [3];
  logic        gt   [3];
  logic        lt   [3];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Rising-edge count, used to measure latency from the accept edge
  always @(posedge clk) cyc <= cyc + 1;

  serial_comp #(.N(16), .D(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .signed_mode(sm[0]),
    .a(a0), .b(b0), .busy(busy[0]), .done(done[0]),
    .eq(eq[0]), .gt(gt[0]), .lt(lt[0])
  );

  serial_comp #(.N(8), .D(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .signed_mode(sm[1]),
    .a(a8[0]), .b(b8[0]), .busy(busy[1]), .done(done[1]),
    .eq(eq[1]), .gt(gt[1]), .lt(lt[1])
  );

  serial_comp #(.N(8), .D(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .signed_mode(sm[2]),
    .a(a8[1]), .b(b8[1]), .busy(busy[2]), .done(done[2]),
    .eq(eq[2]), .gt(gt[2]), .lt(lt[2])
  );

  typedef struct {
    int         dut;
    logic [2:0] res;
    int         lat;
  } exp_t;

  exp_t sb[$];

  function automatic int nb(input int i);
    return (i == 0) ? 16 : 8;
  endfunction

  function automatic int db(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 8 : 1);
  endfunction

  // Operand value as an integer, two's complement when s is set
  function automatic longint sval(input logic [15:0] x, input int n, input logic s);
    longint v;
    v = longint'(x) & ((longint'(1) << n) - 1);
    if (s && x[n-1]) v = v - (longint'(1) << n);
    return v;
  endfunction

  function automatic int exp_lat(input int i, input logic [15:0] x, input logic [15:0] y);
    int n;
    n = nb(i);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    for (int j = n - 1; j >= 0; j--)
      if (x[j] != y[j]) return (n - 1 - j) / db(i) + 2;
`endif
    return n / db(i) + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Present a request; optionally queue the reference result
  task automatic drive(input int i, input logic [15:0] x, input logic [15:0] y,
                       input logic s, input bit push);
    exp_t   e;
    longint va, vb;
    case (i)
      0:       begin a0    = x;      b0    = y;      end
      1:       begin a8[0] = x[7:0]; b8[0] = y[7:0]; end
      default: begin a8[1] = x[7:0]; b8[1] = y[7:0]; end
    endcase
    sm[i] = s;
    st[i] = 1'b1;
    if (push) begin
      va    = sval(x, nb(i), s);
      vb    = sval(y, nb(i), s);
      e.dut = i;
      e.res = (va == vb) ? 3'b100 : ((va > vb) ? 3'b010 : 3'b001);
      e.lat = exp_lat(i, x, y);
      sb.push_back(e);
    end
  endtask

  // Called at a falling edge; k is the edge count of the accept edge
  task automatic wait_done(input int i, input int k);
    exp_t e;
    int   t;
    t = 0;
    while (done[i] !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 32'(done[i]), 32'd1);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("dut_index", 32'(i), 32'(e.dut));
      chk("latency", 32'(cyc - k + 1), 32'(e.lat));
      chk("result_eq_gt_lt", 32'({eq[i], gt[i], lt[i]}), 32'(e.res));
    end
  endtask

  task automatic run_one(input int i, input logic [15:0] x, input logic [15:0] y,
                         input logic s);
    int k;
    @(negedge clk);
    drive(i, x, y, s, 1'b1);
    @(negedge clk);
    k     = cyc;
    st[i] = 1'b0;
    chk("busy_after_start", 32'(busy[i]), 32'd1);
    wait_done(i, k);
    @(negedge clk);
    chk("done_single_cycle", 32'(done[i]), 32'd0);
  endtask

  initial begin
    int k;
    int seen;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      sm[i] = 1'b0;
    end
    a0 = '0; b0 = '0;
    for (int i = 0; i < 2; i++) begin
      a8[i] = '0;
      b8[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk("reset_outputs", 32'({busy[i], done[i], eq[i], gt[i], lt[i]}), 32'd0);
    rst_n = 1'b1;

    // Basic compares on the 16/4 instance
    run_one(0, 16'h1234, 16'h1234, 1'b0);
    run_one(0, 16'hF000, 16'h0FFF, 1'b0);
    run_one(0, 16'hF000, 16'h0FFF, 1'b1);
    run_one(0, 16'h8000, 16'h8001, 1'b1);
    run_one(0, 16'h7FFF, 16'h8000, 1'b1);
    run_one(0, 16'h7FFF, 16'h8000, 1'b0);

    // start during RUN is ignored; start in DONE chains with no IDLE gap
    @(negedge clk);
    drive(0, 16'h00FF, 16'h0F00, 1'b0, 1'b1);
    @(negedge clk);
    k     = cyc;
    st[0] = 1'b0;
    @(negedge clk);
    drive(0, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    st[0] = 1'b0;
    wait_done(0, k);
    drive(0, 16'h7000, 16'h7000, 1'b1, 1'b1);
    @(negedge clk);
    k     = cyc;
    st[0] = 1'b0;
    chk("no_idle_gap_busy", 32'(busy[0]), 32'd1);
    chk("no_idle_gap_done", 32'(done[0]), 32'd0);
    wait_done(0, k);
    @(negedge clk);
    chk("done_single_cycle", 32'(done[0]), 32'd0);

    // Asynchronous abort two edges into a scan
    @(negedge clk);
    drive(0, 16'h1234, 16'h1235, 1'b0, 1'b0);
    @(posedge clk);
    #1 st[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("abort_outputs", 32'({busy[0], done[0], eq[0], gt[0], lt[0]}), 32'd0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done[0] === 1'b1) seen++;
    end
    chk("no_done_after_abort", 32'(seen), 32'd0);
    rst_n = 1'b1;
    run_one(0, 16'hABCD, 16'hABCC, 1'b0);

    // Boundary digit widths: D=N and D=1
    run_one(1, 16'h0080, 16'h007F, 1'b1);
    run_one(2, 16'h0080, 16'h007F, 1'b1);
    run_one(2, 16'h0055, 16'h0055, 1'b0);
    for (int r = 0; r < 8; r++) begin
      run_one(1, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
      run_one(2, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/serial_comp.md
# serial_comp

Parametrised digit-serial magnitude comparator: it generalises the combinational n-bit eq/gt/lt comparator to a multi-cycle, MSB-first engine with a start/done handshake and a signed/unsigned mode. It processes D bits per clock, so the critical path is independent of N. It sits beside arithmetic datapaths where wide operands are compared infrequently and area or timing outweighs latency.

## Interface
- N, default 16: operand width in bits; must be a multiple of D and at least 2.
- D, default 4: digit width compared per cycle; 1 ≤ D ≤ N.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a comparison; sampled only when the block can accept.
- signed_mode  input  1  1 = two's-complement compare; 0 = unsigned. Sampled with start.
- a  input  N  operand A; sampled with start.
- b  input  N  operand B; sampled with start.
- busy  output  1  high while digits are being compared.
- done  output  1  single-cycle pulse; the result is valid from this cycle on.
- eq  output  1  A == B (registered).
- gt  output  1  A > B (registered).
- lt  output  1  A < B (registered).

## Operation
- States: IDLE, RUN, DONE.
- Accept rule: start is accepted when the state is IDLE or DONE. start while busy is ignored and not queued.
- On accept:
  - load a and b into shift registers;
  - if signed_mode, invert bit N-1 of both copies (offset-binary mapping);
  - clear the digit counter and the decided flag;
  - go to RUN.
- Each RUN cycle compares the top D bits of both shift registers:
  - if not yet decided and the digits differ, latch gt or lt from the digit compare and set decided;
  - shift both registers left by D and increment the counter.
- Final digit (counter = N/D-1): go to DONE and register the outputs.
  - eq = ~decided
  - gt or lt as latched
- DONE lasts one cycle with done = 1, then returns to IDLE unless start is accepted in that same cycle.
- After the first completion, exactly one of eq/gt/lt is high. All three hold until the next completion.
- Reset (asynchronous, including mid-RUN): go to IDLE. busy, done, eq, gt and lt all become 0. No done pulse is produced for the aborted operation.

## Timing
- Reset values: busy = 0, done = 0, eq = 0, gt = 0, lt = 0, state = IDLE.
- start accepted at edge k:
  - busy is high from after edge k through edge k+N/D;
  - done and the new eq/gt/lt appear after edge k+N/D.
- Latency: N/D+1 cycles from the start edge to the done cycle.
- Back-to-back throughput: one result per N/D+1 cycles (start asserted during the DONE cycle).
- D = N: single RUN cycle, latency 2.

## Configuration
- SERIAL_COMP_EARLY_EXIT_EN
  - Defined: RUN moves to DONE on the first differing digit, so latency is (i+1)+1 cycles for a first difference at MSB-first digit index i. Equal operands still take the full N/D+1 cycles.
  - Undefined: fixed latency of N/D+1 cycles for every comparison.
  - Results are identical in both builds.

## Structure
- Shared package serial_comp_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the result encoding constants;
  - a function returning the counter width, clog2(N/D).
- One natural sub-module, digit_cmp: combinational D-bit compare producing diff and a_gt. It is instantiated once in the RUN datapath.

## Test plan
- N=16, D=4, unsigned. a=16'h1234, b=16'h1234, start at edge 0 → busy high for 4 cycles, done after edge 4, eq=1 gt=0 lt=0.
- Unsigned, a=16'hF000, b=16'h0FFF → gt=1. Signed, same operands → lt=1 (−4096 < 4095). With SERIAL_COMP_EARLY_EXIT_EN, done arrives after edge 1.
- Signed, a=16'h8000, b=16'h8001 → lt=1 at digit 3. Latency is 5 cycles with or without early exit.
- start pulsed during RUN with different operands → ignored: single done, result reflects the first operands. Then start asserted in the DONE cycle → second result 5 cycles later, no IDLE gap.
- rst_n asserted mid-RUN (after edge 2) → busy, done, eq, gt and lt are 0 immediately. No done follows. A fresh start after release completes normally.
- N=8, D=8, and N=8, D=1 with random operands against a reference compare → correct results, latencies 2 and 9 cycles.
